// File: rtl/data_sram_model_if.sv
// Data SRAM port between the execute/memory stages (master) and the data memory (slave).
// Latency: none, wires only; the responder sets the read latency.
// Backpressure: none; the slave accepts a request every cycle.
// Signals: request = en, we[3:0], addr, wdata; response = rdata, rdata_valid;
//          debug = addr_err (sticky), err_addr (first offending byte address).
interface data_sram_model_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        rdata_valid;
  logic        addr_err;
  logic [31:0] err_addr;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, rdata_valid, addr_err, err_addr
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, rdata_valid, addr_err, err_addr
  );
endinterface

// File: rtl/data_sram_model.sv
// Data memory responder: byte-masked writes, range-checked reads, first-error address capture.
// Latency: read data and rdata_valid READ_LATENCY edges after the request edge; writes have no response.
// Backpressure: none; one request per cycle is always accepted.
// Ports: clk, reset (synchronous, active-high), bus (slave modport of data_sram_model_if).
module data_sram_model #(
  parameter int          ADDR_WIDTH   = 14,
  parameter logic [31:0] BASE_ADDR    = 32'h1C00_0000,
  parameter int          READ_LATENCY = 1
) (
  input logic              clk,
  input logic              reset,
  data_sram_model_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  logic                  in_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  is_rd;
  logic                  is_wr;

  // The window is the aligned 2^(ADDR_WIDTH+2)-byte region at BASE_ADDR;
  // anything else is an error, never aliased into the array.
  assign in_range = (bus.data_sram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign word_idx = bus.data_sram_addr[ADDR_WIDTH+1:2];
  assign is_rd    = bus.data_sram_en && (bus.data_sram_we == 4'h0);
  assign is_wr    = bus.data_sram_en && (bus.data_sram_we != 4'h0);

  // Array storage has no reset; reset only blocks the write on its cycle.
  always_ff @(posedge clk) begin
    if (!reset && is_wr && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_we[i]) begin
          mem[word_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline. Data in a stage only moves when a valid entry moves into
  // it, so the last stage (and hence rdata) holds its value between reads.
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [31:0]             pipe_dat [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_dat[i] <= 32'h0;
      end
    end else begin
      pipe_vld[0] <= is_rd;
      if (is_rd) begin
        pipe_dat[0] <= in_range ? mem[word_idx] : 32'h0;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_dat[i] <= pipe_dat[i-1];
        end
      end
    end
  end

  assign bus.rdata_valid     = pipe_vld[READ_LATENCY-1];
  assign bus.data_sram_rdata = pipe_dat[READ_LATENCY-1];

  // Sticky error flag; only the first offending address is kept.
  logic        err_q;
  logic [31:0] err_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else if (bus.data_sram_en && !in_range) begin
      err_q <= 1'b1;
      if (!err_q) begin
        err_addr_q <= bus.data_sram_addr;
      end
    end
  end

  assign bus.addr_err = err_q;
  assign bus.err_addr = err_addr_q;

endmodule

// File: tb/tb_data_sram_model.sv
// Bench for data_sram_model: three instances (READ_LATENCY 1, 3, 4) share one stimulus stream.
// Expected read responses are queued per instance with their due cycle; a negedge monitor pops them.
// Error flags and held-data values are compared directly after the sampling edge.
module tb_data_sram_model;

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int lat [3] = '{1, 3, 4};

  exp_t q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_model_if if1 ();
  data_sram_model_if if3 ();
  data_sram_model_if if4 ();

  assign if1.data_sram_en = en;  assign if1.data_sram_we = we;
  assign if1.data_sram_addr = addr;  assign if1.data_sram_wdata = wdata;
  assign if3.data_sram_en = en;  assign if3.data_sram_we = we;
  assign if3.data_sram_addr = addr;  assign if3.data_sram_wdata = wdata;
  assign if4.data_sram_en = en;  assign if4.data_sram_we = we;
  assign if4.data_sram_addr = addr;  assign if4.data_sram_wdata = wdata;

  data_sram_model #(.READ_LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(if1.slave));
  data_sram_model #(.READ_LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .bus(if3.slave));
  data_sram_model #(.READ_LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .bus(if4.slave));

  logic        vld  [3];
  logic [31:0] dat  [3];
  logic        aerr [3];
  logic [31:0] eadr [3];

  assign vld[0] = if1.rdata_valid;  assign dat[0] = if1.data_sram_rdata;
  assign vld[1] = if3.rdata_valid;  assign dat[1] = if3.data_sram_rdata;
  assign vld[2] = if4.rdata_valid;  assign dat[2] = if4.data_sram_rdata;
  assign aerr[0] = if1.addr_err;  assign eadr[0] = if1.err_addr;
  assign aerr[1] = if3.addr_err;  assign eadr[1] = if3.err_addr;
  assign aerr[2] = if4.addr_err;  assign eadr[2] = if4.err_addr;

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat=%0d): got %h, expected %h", name, lat[k], act, exp);
    end
  endtask

  // Response monitor: every valid pulse must match the oldest queued read,
  // both in data and in the cycle it was due.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vld[k] === 1'b1) begin
        if (q[k].size() == 0) begin
          check("spurious_rdata_valid", k, 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q[k].pop_front();
          check("rdata", k, dat[k], e.dat);
          check("rdata_cycle", k, cyc, e.due);
        end
      end else if (q[k].size() > 0 && q[k][0].due < cyc) begin
        exp_t e;
        e = q[k].pop_front();
        check("missing_rdata_valid_at_cycle", k, cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [3:0] m, logic [31:0] a, logic [31:0] d);
    en = 1'b1; we = m; addr = a; wdata = d;
    step();
    en = 1'b0; we = 4'h0;
  endtask

  task automatic rd(logic [31:0] a, logic [31:0] exp);
    en = 1'b1; we = 4'h0; addr = a;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.dat = exp;
      e.due = cyc + lat[k];
      q[k].push_back(e);
    end
    step();
    en = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(string name);
    for (int k = 0; k < 3; k++) begin
      check({name, "_rdata"}, k, dat[k], 32'h0);
      check({name, "_rdata_valid"}, k, {31'h0, vld[k]}, 32'h0);
      check({name, "_addr_err"}, k, {31'h0, aerr[k]}, 32'h0);
      check({name, "_err_addr"}, k, eadr[k], 32'h0);
    end
  endtask

  task automatic check_err(string name, logic e, logic [31:0] a);
    for (int k = 0; k < 3; k++) begin
      check({name, "_addr_err"}, k, {31'h0, aerr[k]}, {31'h0, e});
      check({name, "_err_addr"}, k, eadr[k], a);
    end
  endtask

  task automatic check_hold(string name, logic [31:0] exp);
    for (int k = 0; k < 3; k++) begin
      check({name, "_rdata_valid"}, k, {31'h0, vld[k]}, 32'h0);
      check({name, "_rdata"}, k, dat[k], exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    reset = 1'b1;
    idle(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    idle(1);

    // Full write then read
    wr(4'hF, 32'h1C00_0010, 32'hA5A5_1234);
    rd(32'h1C00_0010, 32'hA5A5_1234);
    idle(6);

    // Byte merges
    wr(4'hF, 32'h1C00_0020, 32'h1122_3344);
    wr(4'b0100, 32'h1C00_0020, 32'h00EE_0000);
    rd(32'h1C00_0020, 32'h11EE_3344);
    wr(4'b0011, 32'h1C00_0020, 32'h5555_BEEF);
    rd(32'h1C00_0020, 32'h11EE_BEEF);
    wr(4'b1000, 32'h1C00_0020, 32'h7700_0000);
    rd(32'h1C00_0020, 32'h77EE_BEEF);
    idle(6);

    // Back-to-back reads, then rdata holds the last value
    wr(4'hF, 32'h1C00_0000, 32'h0000_1111);
    wr(4'hF, 32'h1C00_0004, 32'h2222_3333);
    wr(4'hF, 32'h1C00_0008, 32'h4444_5555);
    rd(32'h1C00_0000, 32'h0000_1111);
    rd(32'h1C00_0004, 32'h2222_3333);
    rd(32'h1C00_0008, 32'h4444_5555);
    idle(6);
    check_hold("hold_after_burst", 32'h4444_5555);

    // Top word of the window is in range
    wr(4'hF, 32'h1C00_FFFC, 32'h0BAD_CAFE);
    rd(32'h1C00_FFFC, 32'h0BAD_CAFE);
    idle(6);
    check_err("in_range_top", 1'b0, 32'h0);

    // Out-of-range write: no array change, first address captured
    wr(4'hF, 32'h1C00_0040, 32'hCAFE_F00D);
    wr(4'hF, 32'h0000_0040, 32'h1234_5678);
    check_err("oor_write", 1'b1, 32'h0000_0040);
    rd(32'h1C00_0040, 32'hCAFE_F00D);
    rd(32'h2000_0000, 32'h0000_0000);
    idle(6);
    check_err("oor_read_sticky", 1'b1, 32'h0000_0040);
    check_hold("hold_after_oor_read", 32'h0000_0000);
    // Just past the window must not wrap onto word 0
    wr(4'hF, 32'h1C01_0000, 32'hFFFF_FFFF);
    rd(32'h1C00_0000, 32'h0000_1111);
    idle(6);
    check_err("oor_no_wrap", 1'b1, 32'h0000_0040);

    // Reset clears error state
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check_reset_outputs("reset_clear");

    // Reset with reads in flight; a write during reset is dropped
    rd(32'h1C00_0010, 32'hA5A5_1234);
    step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_t keep [$];
      keep = {};
      foreach (q[k][i]) if (q[k][i].due <= cyc) keep.push_back(q[k][i]);
      q[k] = keep;
    end
    en = 1'b1; we = 4'hF; addr = 32'h1C00_0010; wdata = 32'hFFFF_FFFF;
    step();
    en = 1'b0; we = 4'h0;
    step();
    reset = 1'b0;
    check_reset_outputs("reset_midflight");
    idle(8);
    check_reset_outputs("after_midflight");

    // Idle with garbage on the other inputs
    for (int i = 0; i < 100; i++) begin
      en = 1'b0;
      we = 4'hF;
      addr = (i % 2 == 0) ? (32'h1C00_0000 | ($urandom & 32'h0000_00FC)) : $urandom;
      wdata = $urandom;
      step();
    end
    we = 4'h0;
    check_err("idle_garbage", 1'b0, 32'h0);
    rd(32'h1C00_0010, 32'hA5A5_1234);
    rd(32'h1C00_0020, 32'h77EE_BEEF);
    rd(32'h1C00_0000, 32'h0000_1111);
    rd(32'h1C00_0004, 32'h2222_3333);
    rd(32'h1C00_0008, 32'h4444_5555);
    rd(32'h1C00_0040, 32'hCAFE_F00D);
    idle(8);
    check_hold("hold_final", 32'hCAFE_F00D);

    for (int k = 0; k < 3; k++) begin
      check("pending_reads_left", k, q[k].size(), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_model.md
# data_sram_model

Synchronous data-memory responder: the slave end of the CPU data SRAM port driven by the execute stage. It accepts one request per cycle (`en`, byte-lane `we`, `addr`, `wdata`), performs byte-masked writes into an internal word array, and returns read data after a fixed, parameterized number of clock edges for the memory stage to consume. It also range-checks every access, suppresses out-of-range writes, and latches the first offending address for debug.

## Interface
- `ADDR_WIDTH`, 14: word-index bits; array depth = 2^ADDR_WIDTH 32-bit words.
- `BASE_ADDR`, 32'h1C00_0000: window base; bits [ADDR_WIDTH+1:0] must be zero.
- `READ_LATENCY`, 1: clock edges from read request to `data_sram_rdata`; legal 1..4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_sram_en`  in  1  request valid this cycle.
- `data_sram_we`  in  4  byte-lane write enables; lane i = bits [8i+7:8i]; all-zero = read.
- `data_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32  write data, lane-aligned.
- `data_sram_rdata`  out  32  read data.
- `rdata_valid`  out  1  one-cycle pulse; `data_sram_rdata` carries a read result.
- `addr_err`  out  1  sticky; an out-of-range access has occurred.
- `err_addr`  out  32  byte address of the first out-of-range access.

## Operation
- Request classes, sampled each rising edge: idle (`en`=0, all other inputs ignored); read (`en`=1, `we`=0); write (`en`=1, `we`≠0).
- In range: `addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]`. Word index = `addr[ADDR_WIDTH+1:2]`.
- Write, in range: each lane with `we[i]`=1 takes `wdata` lane i. Other lanes keep their value.
- Read, in range: returns the full stored word. Lane selection and sign extension are done by the consumer.
- Out-of-range access (read or write):
  - the array is not modified;
  - a read returns 32'h0 and still pulses `rdata_valid`;
  - `addr_err` sets to 1;
  - if `addr_err` was 0, `err_addr` captures `addr`.
- Array contents are not initialized and not affected by `reset`. Only the control, pipeline, and error state is reset.
- Read pipeline: a READ_LATENCY-deep shift of {valid, data}. Stage 0 is loaded from the array on the request edge; each later stage shifts by one per edge.
- Writes produce no response, no `rdata_valid`, and never stall. The block is always ready; there is no back-pressure.

## Timing
- Reset values: `data_sram_rdata`=0, `rdata_valid`=0, `addr_err`=0, `err_addr`=0, all pipeline stages invalid/zero. Reset wins over a request in the same cycle: the request is dropped and no write occurs.
- Read issued in cycle t:
  - `rdata_valid`=1 and the data appear in cycle t+READ_LATENCY;
  - `rdata_valid` is 1 for exactly one cycle per read;
  - back-to-back reads give back-to-back valid pulses, in order.
- `data_sram_rdata` holds its last value while `rdata_valid`=0. It does not return to zero between reads.
- Write at cycle t, read of the same word at cycle t+1 or later: the read returns the new data.
- Only one request per cycle exists, so a read and write cannot occur in the same cycle.
- `reset` asserted with reads in flight: all pending responses are discarded, and no `rdata_valid` pulse appears after reset deasserts.
- `addr_err` and `err_addr` update on the edge that samples the offending request. Both are visible the next cycle and stay set until reset.
- Word index wrap: none. Any address outside the window is an error, never aliased.

## Test plan
- Reset then full write: `we`=4'hF, addr 32'h1C00_0010, wdata 32'hA5A5_1234; then read the same address → one cycle later (latency 1) `rdata`=32'hA5A5_1234, `rdata_valid` a single pulse.
- Byte merge:
  - write 32'h1122_3344 with `we`=F to 0x1C00_0020;
  - then `we`=4'b0100 with wdata 32'h00EE_0000;
  - then read → 32'h11EE_3344.
- Back-to-back reads of 0x1C00_0000, 0x1C00_0004, 0x1C00_0008 with READ_LATENCY=3 → three consecutive valid pulses, starting 3 cycles after the first request, data in request order; `rdata` holds the last value afterward.
- Out of range:
  - write to 32'h0000_0040 → array unchanged, `addr_err`=1, `err_addr`=32'h0000_0040;
  - then read 32'h2000_0000 → returns 0, `rdata_valid` pulses, `err_addr` still 32'h0000_0040.
- Reset mid-flight: READ_LATENCY=4, issue a read, assert reset 2 cycles later → no `rdata_valid` pulse ever appears; all outputs at reset values.
- Idle with garbage: `en`=0, `we`=F, random addr/wdata for 100 cycles → no array change (verify by readback), no `rdata_valid`, `addr_err` stays 0.
